// File: rtl/icache_axi_rd_engine.sv
// Instruction-cache refill read engine: turns one refill request into a single
// AXI INCR read burst and streams the returned beats straight to the cache.
module icache_axi_rd_engine #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned MaxBeats  = 4
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_ni,
    input  logic                                                  rd_req_i,
    output logic                                                  rd_gnt_o,
    input  logic [AddrWidth-1:0]                                  rd_addr_i,
    input  logic [((MaxBeats > 1) ? $clog2(MaxBeats) : 1)-1:0]    rd_blen_i,
    input  logic                                                  rd_nc_i,
    input  logic [IdWidth-1:0]                                    rd_id_i,
    output logic                                                  rd_valid_o,
    output logic                                                  rd_last_o,
    output logic [DataWidth-1:0]                                  rd_data_o,
    output logic [IdWidth-1:0]                                    rd_id_o,
    output logic                                                  rd_exokay_o,
    output logic                                                  rd_err_o,
    output logic                                                  ar_valid_o,
    input  logic                                                  ar_ready_i,
    output logic [AddrWidth-1:0]                                  ar_addr_o,
    output logic [7:0]                                            ar_len_o,
    output logic [2:0]                                            ar_size_o,
    output logic [1:0]                                            ar_burst_o,
    output logic [3:0]                                            ar_cache_o,
    output logic [IdWidth-1:0]                                    ar_id_o,
    input  logic                                                  r_valid_i,
    output logic                                                  r_ready_o,
    input  logic [DataWidth-1:0]                                  r_data_i,
    input  logic [1:0]                                            r_resp_i,
    input  logic                                                  r_last_i,
    input  logic [IdWidth-1:0]                                    r_id_i,
    output logic                                                  busy_o
);

    localparam int unsigned BlenWidth = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
    localparam int unsigned OffWidth  = $clog2(DataWidth / 8);
    localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(DataWidth / 8 - 1);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        RDATA
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q;
    logic [BlenWidth-1:0]   blen_q;
    logic                   nc_q;
    logic [IdWidth-1:0]     id_q;
    logic [BlenWidth-1:0]   cnt_q;
    logic                   err_q;

    logic                   capture;
    logic                   ar_hs;
    logic                   beat;
    logic                   beat_final;
    logic                   beat_err;
    logic                   cnt_at_len;
    logic [BlenWidth-1:0]   len_eff;

    // Non-cacheable fetches are always a single beat regardless of blen.
    assign len_eff    = nc_q ? '0 : blen_q;

    assign ar_addr_o  = addr_q & ~AlignMask;
    assign ar_len_o   = 8'(len_eff);
    assign ar_size_o  = 3'(OffWidth);
    assign ar_burst_o = 2'b01;
    assign ar_cache_o = nc_q ? 4'b0000 : 4'b1111;
    assign ar_id_o    = id_q;

    assign ar_hs      = ar_valid_o & ar_ready_i;
    assign rd_gnt_o   = ar_hs;

    assign beat       = r_valid_i & r_ready_o;
    assign cnt_at_len = (cnt_q == len_eff);
    // A burst ends on r_last or on the expected final beat, whichever comes first.
    assign beat_final = beat & (r_last_i | cnt_at_len);
    assign beat_err   = r_resp_i[1] | (r_id_i != id_q);

    assign rd_valid_o  = beat;
    assign rd_data_o   = r_data_i;
    assign rd_id_o     = r_id_i;
    assign rd_last_o   = beat_final;
    assign rd_exokay_o = beat & (r_resp_i == 2'b01);
    assign rd_err_o    = beat_final & (err_q | beat_err | (r_last_i != cnt_at_len));

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;
        busy_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req_i) begin
                    capture = 1'b1;
                    state_d = AR;
                end
            end
            AR: begin
                ar_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (ar_ready_i) state_d = RDATA;
            end
            RDATA: begin
                r_ready_o = 1'b1;
                busy_o    = 1'b1;
                if (beat_final) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            blen_q  <= '0;
            nc_q    <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q <= rd_addr_i;
                blen_q <= rd_blen_i;
                nc_q   <= rd_nc_i;
                id_q   <= rd_id_i;
            end
            if (ar_hs) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (beat) begin
                cnt_q <= cnt_q + BlenWidth'(1);
                err_q <= err_q | beat_err;
            end
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_engine.sv
// Directed self-checking bench for icache_axi_rd_engine (default parameters:
// 64-bit address/data, 4-bit IDs, bursts of up to 4 beats).
module tb_icache_axi_rd_engine;

    logic        clk_i;
    logic        rst_ni;
    logic        rd_req_i;
    logic        rd_gnt_o;
    logic [63:0] rd_addr_i;
    logic [1:0]  rd_blen_i;
    logic        rd_nc_i;
    logic [3:0]  rd_id_i;
    logic        rd_valid_o;
    logic        rd_last_o;
    logic [63:0] rd_data_o;
    logic [3:0]  rd_id_o;
    logic        rd_exokay_o;
    logic        rd_err_o;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic [3:0]  ar_cache_o;
    logic [3:0]  ar_id_o;
    logic        r_valid_i;
    logic        r_ready_o;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_last_i;
    logic [3:0]  r_id_i;
    logic        busy_o;

    int checks    = 0;
    int failures  = 0;
    int gnt_count = 0;
    int exp_gnts  = 0;

    icache_axi_rd_engine dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rd_req_i    (rd_req_i),
        .rd_gnt_o    (rd_gnt_o),
        .rd_addr_i   (rd_addr_i),
        .rd_blen_i   (rd_blen_i),
        .rd_nc_i     (rd_nc_i),
        .rd_id_i     (rd_id_i),
        .rd_valid_o  (rd_valid_o),
        .rd_last_o   (rd_last_o),
        .rd_data_o   (rd_data_o),
        .rd_id_o     (rd_id_o),
        .rd_exokay_o (rd_exokay_o),
        .rd_err_o    (rd_err_o),
        .ar_valid_o  (ar_valid_o),
        .ar_ready_i  (ar_ready_i),
        .ar_addr_o   (ar_addr_o),
        .ar_len_o    (ar_len_o),
        .ar_size_o   (ar_size_o),
        .ar_burst_o  (ar_burst_o),
        .ar_cache_o  (ar_cache_o),
        .ar_id_o     (ar_id_o),
        .r_valid_i   (r_valid_i),
        .r_ready_o   (r_ready_o),
        .r_data_i    (r_data_i),
        .r_resp_i    (r_resp_i),
        .r_last_i    (r_last_i),
        .r_id_i      (r_id_i),
        .busy_o      (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(negedge clk_i) begin
        if (rd_gnt_o) gnt_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues one request, holds AR off for ar_delay cycles, then completes the handshake.
    task automatic applyStimulus(input string tag, input logic [63:0] addr, input logic [1:0] blen,
                                 input logic nc, input logic [3:0] id, input int ar_delay, input bit drop_req,
                                 input logic [63:0] exp_addr, input logic [7:0] exp_len, input logic [3:0] exp_cache);
        rd_req_i  = 1'b1;
        rd_addr_i = addr;
        rd_blen_i = blen;
        rd_nc_i   = nc;
        rd_id_i   = id;
        @(negedge clk_i);
        checkOutput({tag, "_idle_arvalid"}, ar_valid_o, 0);
        checkOutput({tag, "_idle_busy"}, busy_o, 0);
        tick();
        if (drop_req) rd_req_i = 1'b0;
        rd_addr_i = 64'hDEAD_BEEF_DEAD_BEEF;
        rd_blen_i = ~blen;
        rd_nc_i   = ~nc;
        rd_id_i   = ~id;
        r_valid_i = 1'b1;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk_i);
            checkOutput({tag, "_wait_arvalid"}, ar_valid_o, 1);
            checkOutput({tag, "_wait_gnt"}, rd_gnt_o, 0);
            checkOutput({tag, "_wait_rvalid_blocked"}, rd_valid_o, 0);
            tick();
        end
        ar_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput({tag, "_arvalid"}, ar_valid_o, 1);
        checkOutput({tag, "_gnt"}, rd_gnt_o, 1);
        checkOutput({tag, "_busy"}, busy_o, 1);
        checkOutput({tag, "_rready_in_ar"}, r_ready_o, 0);
        checkOutput({tag, "_rvalid_blocked"}, rd_valid_o, 0);
        checkOutput({tag, "_araddr"}, ar_addr_o, exp_addr);
        checkOutput({tag, "_arlen"}, ar_len_o, exp_len);
        checkOutput({tag, "_arsize"}, ar_size_o, 3);
        checkOutput({tag, "_arburst"}, ar_burst_o, 1);
        checkOutput({tag, "_arcache"}, ar_cache_o, exp_cache);
        checkOutput({tag, "_arid"}, ar_id_o, id);
        tick();
        ar_ready_i = 1'b0;
        rd_req_i   = 1'b0;
        r_valid_i  = 1'b0;
        exp_gnts++;
        checkOutput({tag, "_gnt_count"}, gnt_count, exp_gnts);
    endtask

    task automatic sendBeat(input string tag, input logic [63:0] data, input logic [1:0] resp, input logic last,
                            input logic [3:0] id, input logic exp_last, input logic exp_err);
        r_valid_i = 1'b1;
        r_data_i  = data;
        r_resp_i  = resp;
        r_last_i  = last;
        r_id_i    = id;
        @(negedge clk_i);
        checkOutput({tag, "_rready"}, r_ready_o, 1);
        checkOutput({tag, "_valid"}, rd_valid_o, 1);
        checkOutput({tag, "_data"}, rd_data_o, data);
        checkOutput({tag, "_id"}, rd_id_o, id);
        checkOutput({tag, "_last"}, rd_last_o, exp_last);
        checkOutput({tag, "_err"}, rd_err_o, exp_err);
        checkOutput({tag, "_exokay"}, rd_exokay_o, (resp == 2'b01) ? 1 : 0);
        tick();
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
        r_resp_i  = 2'b00;
    endtask

    task automatic gapCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            r_valid_i = 1'b0;
            r_data_i  = {$urandom, $urandom};
            @(negedge clk_i);
            checkOutput({tag, "_gap_valid"}, rd_valid_o, 0);
            checkOutput({tag, "_gap_busy"}, busy_o, 1);
            tick();
        end
    endtask

    // A beat offered while idle must be ignored.
    task automatic idleCheck(input string tag);
        r_valid_i = 1'b1;
        r_last_i  = 1'b1;
        @(negedge clk_i);
        checkOutput({tag, "_post_busy"}, busy_o, 0);
        checkOutput({tag, "_post_rready"}, r_ready_o, 0);
        checkOutput({tag, "_post_arvalid"}, ar_valid_o, 0);
        checkOutput({tag, "_post_valid"}, rd_valid_o, 0);
        checkOutput({tag, "_post_last"}, rd_last_o, 0);
        tick();
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        rd_req_i   = 1'b1;
        rd_addr_i  = '0;
        rd_blen_i  = '0;
        rd_nc_i    = 1'b0;
        rd_id_i    = '0;
        ar_ready_i = 1'b1;
        r_valid_i  = 1'b1;
        r_data_i   = '0;
        r_resp_i   = 2'b10;
        r_last_i   = 1'b1;
        r_id_i     = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_arvalid", ar_valid_o, 0);
        checkOutput("reset_rready", r_ready_o, 0);
        checkOutput("reset_gnt", rd_gnt_o, 0);
        checkOutput("reset_valid", rd_valid_o, 0);
        checkOutput("reset_last", rd_last_o, 0);
        checkOutput("reset_err", rd_err_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_araddr", ar_addr_o, 0);
        tick();
        rst_ni     = 1'b1;
        rd_req_i   = 1'b0;
        ar_ready_i = 1'b0;
        r_valid_i  = 1'b0;
        r_resp_i   = 2'b00;
        r_last_i   = 1'b0;
        tick();

        applyStimulus("cach", 64'h0000_0000_8000_1234, 2'd3, 1'b0, 4'd5, 3, 1'b0,
                      64'h0000_0000_8000_1230, 8'd3, 4'b1111);
        sendBeat("cach_b1", 64'h1111_0000_0000_0001, 2'b00, 1'b0, 4'd5, 1'b0, 1'b0);
        sendBeat("cach_b2", 64'h1111_0000_0000_0002, 2'b00, 1'b0, 4'd5, 1'b0, 1'b0);
        sendBeat("cach_b3", 64'h1111_0000_0000_0003, 2'b01, 1'b0, 4'd5, 1'b0, 1'b0);
        sendBeat("cach_b4", 64'h1111_0000_0000_0004, 2'b00, 1'b1, 4'd5, 1'b1, 1'b0);
        idleCheck("cach");

        applyStimulus("nc", 64'h0000_0000_1000_000F, 2'd3, 1'b1, 4'd2, 0, 1'b1,
                      64'h0000_0000_1000_0008, 8'd0, 4'b0000);
        sendBeat("nc_b1", 64'h2222_2222_2222_2222, 2'b00, 1'b1, 4'd2, 1'b1, 1'b0);
        idleCheck("nc");

        applyStimulus("slv", 64'h0000_0000_0000_0040, 2'd3, 1'b0, 4'd7, 1, 1'b0,
                      64'h0000_0000_0000_0040, 8'd3, 4'b1111);
        sendBeat("slv_b1", 64'h3333_0000_0000_0001, 2'b00, 1'b0, 4'd7, 1'b0, 1'b0);
        sendBeat("slv_b2", 64'h3333_0000_0000_0002, 2'b10, 1'b0, 4'd7, 1'b0, 1'b0);
        sendBeat("slv_b3", 64'h3333_0000_0000_0003, 2'b00, 1'b0, 4'd7, 1'b0, 1'b0);
        sendBeat("slv_b4", 64'h3333_0000_0000_0004, 2'b00, 1'b1, 4'd7, 1'b1, 1'b1);
        idleCheck("slv");

        applyStimulus("early", 64'h0000_0000_0000_0100, 2'd3, 1'b0, 4'd1, 0, 1'b0,
                      64'h0000_0000_0000_0100, 8'd3, 4'b1111);
        sendBeat("early_b1", 64'h4444_0000_0000_0001, 2'b00, 1'b0, 4'd1, 1'b0, 1'b0);
        sendBeat("early_b2", 64'h4444_0000_0000_0002, 2'b00, 1'b1, 4'd1, 1'b1, 1'b1);
        idleCheck("early");

        applyStimulus("nolast", 64'h0000_0000_0000_0207, 2'd3, 1'b0, 4'd6, 0, 1'b0,
                      64'h0000_0000_0000_0200, 8'd3, 4'b1111);
        sendBeat("nolast_b1", 64'h5555_0000_0000_0001, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0);
        sendBeat("nolast_b2", 64'h5555_0000_0000_0002, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0);
        sendBeat("nolast_b3", 64'h5555_0000_0000_0003, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0);
        sendBeat("nolast_b4", 64'h5555_0000_0000_0004, 2'b00, 1'b0, 4'd6, 1'b1, 1'b1);
        idleCheck("nolast");

        applyStimulus("idmis", 64'h0000_0000_0000_0300, 2'd1, 1'b0, 4'd3, 0, 1'b0,
                      64'h0000_0000_0000_0300, 8'd1, 4'b1111);
        sendBeat("idmis_b1", 64'h6666_0000_0000_0001, 2'b00, 1'b0, 4'd4, 1'b0, 1'b0);
        sendBeat("idmis_b2", 64'h6666_0000_0000_0002, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1);
        idleCheck("idmis");

        // Back-to-back: the next request is already pending during the final beat.
        applyStimulus("b2bA", 64'h0000_0000_0000_2000, 2'd3, 1'b0, 4'd9, 2, 1'b0,
                      64'h0000_0000_0000_2000, 8'd3, 4'b1111);
        for (int b = 0; b < 3; b++) begin
            gapCycles("b2bA", $urandom_range(0, 2));
            sendBeat("b2bA_beat", 64'hA000_0000_0000_0000 + 64'(b), 2'b00, 1'b0, 4'd9, 1'b0, 1'b0);
        end
        gapCycles("b2bA", $urandom_range(0, 2));
        rd_req_i  = 1'b1;
        rd_addr_i = 64'hFFFF_FFFF_FFFF_FFF8;
        sendBeat("b2bA_b4", 64'hA000_0000_0000_0003, 2'b00, 1'b1, 4'd9, 1'b1, 1'b0);
        applyStimulus("b2bB", 64'h0000_0000_0000_300C, 2'd1, 1'b0, 4'd10, 0, 1'b0,
                      64'h0000_0000_0000_3008, 8'd1, 4'b1111);
        gapCycles("b2bB", $urandom_range(0, 2));
        sendBeat("b2bB_b1", 64'hB000_0000_0000_0000, 2'b00, 1'b0, 4'd10, 1'b0, 1'b0);
        gapCycles("b2bB", $urandom_range(0, 2));
        sendBeat("b2bB_b2", 64'hB000_0000_0000_0001, 2'b00, 1'b1, 4'd10, 1'b1, 1'b0);
        idleCheck("b2bB");

        applyStimulus("rst", 64'h0000_0000_0000_4000, 2'd3, 1'b0, 4'd11, 0, 1'b0,
                      64'h0000_0000_0000_4000, 8'd3, 4'b1111);
        sendBeat("rst_b1", 64'hC000_0000_0000_0001, 2'b10, 1'b0, 4'd11, 1'b0, 1'b0);
        r_valid_i = 1'b1;
        r_last_i  = 1'b1;
        r_data_i  = 64'hC000_0000_0000_0002;
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_async_valid", rd_valid_o, 0);
        checkOutput("rst_async_rready", r_ready_o, 0);
        checkOutput("rst_async_last", rd_last_o, 0);
        checkOutput("rst_async_err", rd_err_o, 0);
        checkOutput("rst_async_busy", busy_o, 0);
        checkOutput("rst_async_arvalid", ar_valid_o, 0);
        tick();
        @(negedge clk_i);
        checkOutput("rst_hold_valid", rd_valid_o, 0);
        tick();
        rst_ni    = 1'b1;
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
        tick();
        checkOutput("rst_quiet_busy", busy_o, 0);
        applyStimulus("post", 64'h0000_0000_0000_5010, 2'd1, 1'b0, 4'd12, 0, 1'b0,
                      64'h0000_0000_0000_5010, 8'd1, 4'b1111);
        sendBeat("post_b1", 64'hD000_0000_0000_0001, 2'b00, 1'b0, 4'd12, 1'b0, 1'b0);
        sendBeat("post_b2", 64'hD000_0000_0000_0002, 2'b00, 1'b1, 4'd12, 1'b1, 1'b0);
        idleCheck("post");
        checkOutput("final_gnt_count", gnt_count, exp_gnts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_axi_rd_engine.md
ICACHE_AXI_RD_ENGINE -- requirements
Module: icache_axi_rd_engine

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, AXI address width.
REQ-002 SHALL have parameter DataWidth, default 64, AXI data width (power of two, >=32).
REQ-003 SHALL have parameter IdWidth, default 4, AXI ID width.
REQ-004 SHALL have parameter MaxBeats, default 4, largest burst length in beats.
REQ-005 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_req_i  in  1  refill request valid, held until rd_gnt_o.
REQ-008 SHALL have port rd_gnt_o  out  1  one-cycle pulse on AR handshake.
REQ-009 SHALL have port rd_addr_i  in  AddrWidth  request byte address.
REQ-010 SHALL have port rd_blen_i  in  $clog2(MaxBeats)  beats minus one.
REQ-011 SHALL have port rd_nc_i  in  1  non-cacheable request.
REQ-012 SHALL have port rd_id_i  in  IdWidth  transaction ID.
REQ-013 SHALL have ports rd_valid_o/rd_last_o  out  1/1  beat valid / final beat.
REQ-014 SHALL have ports rd_data_o/rd_id_o  out  DataWidth/IdWidth  beat data / ID.
REQ-015 SHALL have ports rd_exokay_o/rd_err_o  out  1/1  EXOKAY on beat / accumulated error, valid with rd_last_o.
REQ-016 SHALL have ports ar_valid_o, ar_ready_i, ar_addr_o, ar_len_o(8), ar_size_o(3), ar_burst_o(2), ar_cache_o(4), ar_id_o  AXI AR channel.
REQ-017 SHALL have ports r_valid_i, r_ready_o, r_data_i, r_resp_i(2), r_last_i, r_id_i  AXI R channel.
REQ-018 SHALL have port busy_o  out  1  transaction in flight.

Function
REQ-019 SHALL implement FSM IDLE -> AR (on rd_req_i) -> RDATA (on ar_valid_o & ar_ready_i) -> IDLE (on accepted beat with r_last_i); one transaction outstanding.
REQ-020 SHALL register addr/blen/nc/id in IDLE on rd_req_i; ar_valid_o asserts the following cycle and stays high with stable payload until ar_ready_i.
REQ-021 SHALL drive ar_addr_o = captured address aligned down to DataWidth/8 bytes; ar_len_o = zero-extended blen, forced 0 when nc.
REQ-022 SHALL drive ar_size_o = $clog2(DataWidth/8), ar_burst_o = 2'b01 (INCR), ar_cache_o = 4'b0000 if nc else 4'b1111.
REQ-023 SHALL pulse rd_gnt_o exactly in the AR handshake cycle; rd_req_i deassertion before grant is ignored (request already captured).
REQ-024 SHALL assert r_ready_o only in RDATA; beats arriving in other states are not accepted.
REQ-025 SHALL pass accepted beats combinationally: rd_valid_o = r_valid_i & r_ready_o, rd_data_o = r_data_i, rd_id_o = r_id_i, zero-latency.
REQ-026 SHALL count accepted beats in a counter cleared on AR handshake; rd_last_o = accepted beat with r_last_i.
REQ-027 SHALL set rd_err_o on the last beat if any beat of the burst had r_resp_i[1]=1, or r_last_i arrived at count != ar_len, or r_id_i != captured ID.
REQ-028 SHALL, when count reaches ar_len without r_last_i, treat that beat as last (rd_last_o=1, rd_err_o=1) and return to IDLE.
REQ-029 SHALL drive rd_exokay_o = accepted beat & r_resp_i==2'b01.
REQ-030 SHALL accept a new rd_req_i in the cycle after returning to IDLE (no back-to-back in same cycle as last beat).
REQ-031 busy_o SHALL be high in AR and RDATA.

Reset
REQ-032 On rst_ni low, SHALL go to IDLE immediately; ar_valid_o, r_ready_o, rd_gnt_o, rd_valid_o, rd_last_o, rd_err_o, busy_o = 0; counter, error flag, captured fields = 0.
REQ-033 Reset mid-burst SHALL abandon the transaction; no outputs asserted until a new request.

Verification
REQ-034 Cacheable: addr 0x8000_1234, blen 3, ar_ready delayed 3 cycles -> ar_addr 0x8000_1230, len 3, cache 1111, one gnt pulse, 4 beats, rd_last on 4th, rd_err 0.
REQ-035 Non-cacheable: rd_nc_i=1, blen 3 -> ar_len 0, cache 0000, single beat with rd_last.
REQ-036 SLVERR (resp 2'b10) on beat 2 of 4 -> rd_err_o=1 with rd_last_o on beat 4.
REQ-037 Early r_last on beat 2 of len 3 -> rd_last_o and rd_err_o on beat 2, FSM IDLE next cycle; missing r_last on beat 4 -> forced last with error.
REQ-038 r_valid gaps with random stalls and back-to-back requests -> data order preserved, busy_o correct, gnt once per request.
REQ-039 rst_ni low during beat 2 -> all outputs 0 asynchronously, next request starts clean with counter 0.
